// File: rtl/l2_arb_pkg.sv
// Shared types and default geometry for the L2 read arbiter.
// Holds the source tag encoding, the grant FSM states and the burst geometry.
package l2_arb_pkg;

    // Default geometry: 128-bit L2 bus, 512-bit cache block, 4 outstanding reads
    localparam int unsigned L2_W          = 7;
    localparam int unsigned L2_B          = 9;
    localparam int unsigned L2_ADDR_WIDTH = 30;
    localparam int unsigned L2_Q          = 2;

    // Beats per block and width of the beat counter
    localparam int unsigned BEAT_W   = L2_B - L2_W;
    localparam int unsigned L2_BURST = 1 << BEAT_W;

    // Who a request came from; this bit is what the tag FIFO stores
    typedef enum logic {
        SRC_INS = 1'b0,
        SRC_DAT = 1'b1
    } src_e;

    // Address-channel grant FSM
    typedef enum logic [1:0] {
        GNT_IDLE     = 2'd0,
        GNT_HOLD_INS = 2'd1,
        GNT_HOLD_DAT = 2'd2
    } gnt_state_e;

    // The source that gets the next tie once s has been served
    function automatic src_e other_src(input src_e s);
        return (s == SRC_INS) ? SRC_DAT : SRC_INS;
    endfunction

endpackage

// File: rtl/l2_arb_tag_fifo.sv
// Tag FIFO for the L2 read arbiter: remembers, in request order, which cache
// each accepted read belongs to. 1 bit wide, 2^Q deep, zero-latency head.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module l2_arb_tag_fifo
    import l2_arb_pkg::*;
#(
    parameter int unsigned Q = L2_Q
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned DEPTH    = 1 << Q;
    localparam logic [Q:0]   FULL_CNT = (Q + 1)'(DEPTH);
    localparam logic [Q:0]   CNT_ONE  = 1;
    localparam logic [Q-1:0] PTR_ONE  = 1;

    logic         mem_reg [DEPTH];
    logic [Q-1:0] wr_ptr_reg;
    logic [Q-1:0] rd_ptr_reg;
    logic [Q:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop && !empty;
    // When full, the slot being popped this cycle is reused by the push
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_reg[rd_ptr_reg];

    // Tag storage; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/l2_read_arbiter.sv
// L2 read arbiter: shares one L2 read port between the I-cache and D-cache.
// Requests are arbitrated onto the L2 address channel, the source of each
// accepted read is queued in a tag FIFO, and returning bursts are steered to
// the cache at the FIFO head with no added latency.
// Build option L2_ARB_FIXED_PRIO_EN: D-cache always wins a tie (no round-robin).
module l2_read_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned W          = L2_W,
    parameter int unsigned B          = L2_B,
    parameter int unsigned ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int unsigned Q          = L2_Q
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [ADDR_WIDTH-1:0]   ADDR_TO_L2_INS,
    input  logic                    ADDR_TO_L2_VALID_INS,
    output logic                    ADDR_TO_L2_READY_INS,
    output logic [(1 << W)-1:0]     DATA_FROM_L2_INS,
    output logic                    DATA_FROM_L2_VALID_INS,
    input  logic                    DATA_FROM_L2_READY_INS,
    input  logic [ADDR_WIDTH-1:0]   RD_ADDR_TO_L2_DAT,
    input  logic                    RD_ADDR_TO_L2_VALID_DAT,
    output logic                    RD_ADDR_TO_L2_READY_DAT,
    output logic [(1 << W)-1:0]     DATA_FROM_L2_DAT,
    output logic                    DATA_FROM_L2_VALID_DAT,
    input  logic                    DATA_FROM_L2_READY_DAT,
    output logic [ADDR_WIDTH-1:0]   L2_RD_ADDR,
    output logic                    L2_RD_ADDR_VALID,
    input  logic                    L2_RD_ADDR_READY,
    output logic                    L2_RD_SRC,
    input  logic [(1 << W)-1:0]     L2_RD_DATA,
    input  logic                    L2_RD_DATA_VALID,
    output logic                    L2_RD_DATA_READY
);

    localparam int unsigned      DATA_W    = 1 << W;
    localparam int unsigned      CNT_W     = B - W;
    localparam logic [CNT_W-1:0] LAST_BEAT = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    gnt_state_e            state_reg;
    logic [ADDR_WIDTH-1:0] hold_addr_reg;
    logic [CNT_W-1:0]      beat_cnt_reg;
`ifndef L2_ARB_FIXED_PRIO_EN
    src_e                  rr_prio_reg;   // source that wins the next tie
`endif

    src_e                  winner;
    logic                  gnt_valid;
    src_e                  gnt_src;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  addr_fire;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_head;
    src_e                  head_src;
    logic                  dst_ready;
    logic                  beat_fire;
    logic                  pop_now;
    logic                  slot_free;

    logic [1:0]            req_ready;
    logic [1:0]            rtn_valid;
    logic [DATA_W-1:0]     rtn_data [2];

    // ------------------------------------------------------------------
    // Return path
    // ------------------------------------------------------------------
    assign head_src  = src_e'(fifo_head);
    assign dst_ready = (head_src == SRC_DAT) ? DATA_FROM_L2_READY_DAT : DATA_FROM_L2_READY_INS;
    // Nothing is acknowledged while reset is held or no read is outstanding
    assign L2_RD_DATA_READY = RSTN && !fifo_empty && dst_ready;
    assign beat_fire = L2_RD_DATA_VALID && L2_RD_DATA_READY;
    assign pop_now   = beat_fire && (beat_cnt_reg == LAST_BEAT);
    // A burst finishing this cycle frees its slot for a same-cycle grant
    assign slot_free = !fifo_full || pop_now;

    // ------------------------------------------------------------------
    // Per-source handshakes and data steering
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        localparam src_e SRC_G = (gi == 0) ? SRC_INS : SRC_DAT;
        assign req_ready[gi] = gnt_valid && (gnt_src == SRC_G) && L2_RD_ADDR_READY;
        assign rtn_valid[gi] = L2_RD_DATA_VALID && RSTN && !fifo_empty && (head_src == SRC_G);
        assign rtn_data[gi]  = rtn_valid[gi] ? L2_RD_DATA : '0;
    end

    assign ADDR_TO_L2_READY_INS    = req_ready[0];
    assign RD_ADDR_TO_L2_READY_DAT = req_ready[1];
    assign DATA_FROM_L2_VALID_INS  = rtn_valid[0];
    assign DATA_FROM_L2_VALID_DAT  = rtn_valid[1];
    assign DATA_FROM_L2_INS        = rtn_data[0];
    assign DATA_FROM_L2_DAT        = rtn_data[1];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Pick the source to serve if a new grant is made this cycle
    always_comb begin
        winner = SRC_INS;
`ifdef L2_ARB_FIXED_PRIO_EN
        if (RD_ADDR_TO_L2_VALID_DAT) begin
            winner = SRC_DAT;
        end
`else
        if (ADDR_TO_L2_VALID_INS && RD_ADDR_TO_L2_VALID_DAT) begin
            winner = rr_prio_reg;
        end else if (RD_ADDR_TO_L2_VALID_DAT) begin
            winner = SRC_DAT;
        end
`endif
    end

    // Drive the L2 address channel from the current (new or locked) grant
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_INS;
        gnt_addr  = '0;
        if (RSTN) begin
            case (state_reg)
                GNT_HOLD_INS: begin
                    gnt_valid = 1'b1;
                    gnt_src   = SRC_INS;
                    gnt_addr  = hold_addr_reg;
                end
                GNT_HOLD_DAT: begin
                    gnt_valid = 1'b1;
                    gnt_src   = SRC_DAT;
                    gnt_addr  = hold_addr_reg;
                end
                default: begin
                    if ((ADDR_TO_L2_VALID_INS || RD_ADDR_TO_L2_VALID_DAT) && slot_free) begin
                        gnt_valid = 1'b1;
                        gnt_src   = winner;
                        gnt_addr  = (winner == SRC_DAT) ? RD_ADDR_TO_L2_DAT : ADDR_TO_L2_INS;
                    end
                end
            endcase
        end
    end

    assign addr_fire        = gnt_valid && L2_RD_ADDR_READY;
    assign L2_RD_ADDR_VALID = gnt_valid;
    assign L2_RD_ADDR       = gnt_addr;
    assign L2_RD_SRC        = gnt_src;

    // Grant FSM: lock an unaccepted grant (and its address) until L2 takes it
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg     <= GNT_IDLE;
            hold_addr_reg <= '0;
`ifndef L2_ARB_FIXED_PRIO_EN
            rr_prio_reg   <= SRC_INS;
`endif
        end else begin
            case (state_reg)
                GNT_IDLE: begin
                    if (gnt_valid && !L2_RD_ADDR_READY) begin
                        state_reg     <= (gnt_src == SRC_DAT) ? GNT_HOLD_DAT : GNT_HOLD_INS;
                        hold_addr_reg <= gnt_addr;
                    end
                end
                GNT_HOLD_INS, GNT_HOLD_DAT: begin
                    if (L2_RD_ADDR_READY) begin
                        state_reg <= GNT_IDLE;
                    end
                end
                default: state_reg <= GNT_IDLE;
            endcase
`ifndef L2_ARB_FIXED_PRIO_EN
            if (addr_fire) begin
                rr_prio_reg <= other_src(gnt_src);
            end
`endif
        end
    end

    // Beat counter within the burst at the FIFO head; wraps on the last beat
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            beat_cnt_reg <= '0;
        end else if (beat_fire) begin
            beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + CNT_ONE;
        end
    end

    l2_arb_tag_fifo #(
        .Q (Q)
    ) u_tag_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (addr_fire),
        .din   (gnt_src),
        .pop   (pop_now),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Testbench for l2_read_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
// Honours L2_ARB_FIXED_PRIO_EN the same way the design does.
module tb_l2_read_arbiter;
    import l2_arb_pkg::*;

    localparam int DW    = 1 << L2_W;
    localparam int AW    = L2_ADDR_WIDTH;
    localparam int DEPTH = 1 << L2_Q;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] ins_a, dat_a, l2_a;
    logic          ins_v, dat_v, ins_ar, dat_ar;
    logic [DW-1:0] ins_d, dat_d, l2_d;
    logic          ins_dv, dat_dv, ins_take, dat_take;
    logic          l2_av, l2_ar, l2_src, l2_dv, l2_dr;

    always #5 clk = ~clk;

    l2_read_arbiter #(
        .W(L2_W), .B(L2_B), .ADDR_WIDTH(L2_ADDR_WIDTH), .Q(L2_Q)
    ) dut (
        .CLK                     (clk),
        .RSTN                    (rstn),
        .ADDR_TO_L2_INS          (ins_a),
        .ADDR_TO_L2_VALID_INS    (ins_v),
        .ADDR_TO_L2_READY_INS    (ins_ar),
        .DATA_FROM_L2_INS        (ins_d),
        .DATA_FROM_L2_VALID_INS  (ins_dv),
        .DATA_FROM_L2_READY_INS  (ins_take),
        .RD_ADDR_TO_L2_DAT       (dat_a),
        .RD_ADDR_TO_L2_VALID_DAT (dat_v),
        .RD_ADDR_TO_L2_READY_DAT (dat_ar),
        .DATA_FROM_L2_DAT        (dat_d),
        .DATA_FROM_L2_VALID_DAT  (dat_dv),
        .DATA_FROM_L2_READY_DAT  (dat_take),
        .L2_RD_ADDR              (l2_a),
        .L2_RD_ADDR_VALID        (l2_av),
        .L2_RD_ADDR_READY        (l2_ar),
        .L2_RD_SRC               (l2_src),
        .L2_RD_DATA              (l2_d),
        .L2_RD_DATA_VALID        (l2_dv),
        .L2_RD_DATA_READY        (l2_dr)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding reads as a queue of sources, beat index
    // inside the head burst, tie-break favourite, and a pending unaccepted grant.
    int            q[$];
    int            glog[$];
    int            beat = 0;
    int            prio = 0;
    bit            hold = 0;
    int            hold_src = 0;
    logic [AW-1:0] hold_addr = '0;
    bit            e_gv, e_fire, e_acc;
    int            e_gs;
    logic [AW-1:0] e_ga;

    // Mid-cycle: compute what the outputs must be and compare
    task automatic eval();
        bit ne, drdy, pop, vi, vd;
        int head;
        #4;
        e_gv = 0; e_gs = 0; e_ga = '0; e_fire = 0; e_acc = 0;
        if (!rstn) return;
        ne   = (q.size() > 0);
        head = ne ? q[0] : 0;
        drdy = ne && ((head == 1) ? dat_take : ins_take);
        e_fire = l2_dv && drdy;
        pop  = e_fire && (beat == L2_BURST - 1);
        if (hold) begin
            e_gv = 1; e_gs = hold_src; e_ga = hold_addr;
        end else if ((ins_v || dat_v) && (q.size() < DEPTH || pop)) begin
`ifdef L2_ARB_FIXED_PRIO_EN
            e_gs = dat_v ? 1 : 0;
`else
            if (ins_v && dat_v) e_gs = prio;
            else                e_gs = dat_v ? 1 : 0;
`endif
            e_gv = 1;
            e_ga = (e_gs == 1) ? dat_a : ins_a;
        end
        e_acc = e_gv && l2_ar;
        vi = l2_dv && ne && (head == 0);
        vd = l2_dv && ne && (head == 1);
        check_val("addr_valid", l2_av, e_gv);
        check_val("addr", l2_a, e_ga);
        check_val("src", l2_src, e_gs);
        check_val("ins_addr_ready", ins_ar, e_acc && e_gs == 0);
        check_val("dat_addr_ready", dat_ar, e_acc && e_gs == 1);
        check_val("data_ready", l2_dr, drdy);
        check_val("ins_valid", ins_dv, vi);
        check_val("ins_data", ins_d, vi ? l2_d : '0);
        check_val("dat_valid", dat_dv, vd);
        check_val("dat_data", dat_d, vd ? l2_d : '0);
    endtask

    // Apply this cycle's handshakes to the model, then move to the next cycle
    task automatic adv();
        if (!rstn) begin
            q.delete(); beat = 0; prio = 0; hold = 0;
        end else begin
            if (e_fire) begin
                if (beat == L2_BURST - 1) begin
                    beat = 0;
                    $display("burst done src=%0d", q[0]);
                    void'(q.pop_front());
                end else begin
                    beat++;
                end
            end
            if (e_acc) begin
                q.push_back(e_gs);
                glog.push_back(e_gs);
                prio = 1 - e_gs;
                hold = 0;
                $display("grant src=%0d addr=%0h", e_gs, e_ga);
            end else if (e_gv) begin
                hold = 1; hold_src = e_gs; hold_addr = e_ga;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        eval();
        adv();
    endtask

    task automatic idle_inputs();
        ins_v = 0; dat_v = 0; ins_a = '0; dat_a = '0; l2_ar = 0;
        l2_dv = 0; l2_d = '0; ins_take = 1; dat_take = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        cycle();
        cycle();
        rstn = 1;
    endtask

    // Return every outstanding burst with random data
    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 80 && q.size() > 0; i++) begin
            l2_dv = 1;
            l2_d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        l2_dv = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        bit ip, dp;
        idle_inputs();
        rstn = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset, then a stray return beat with nothing outstanding
        for (int i = 0; i < 10; i++) cycle();
        l2_dv = 1; l2_d = 128'h55;
        eval();
        check_val("empty_no_ack", l2_dr, 0);
        check_val("empty_no_fwd", ins_dv, 0);
        adv();
        idle_inputs();

        // Single I-cache read and its 4-beat return
        ins_v = 1; ins_a = AW'(32'h100); l2_ar = 1;
        eval();
        check_val("t2_ins_ready", ins_ar, 1);
        check_val("t2_src", l2_src, 0);
        adv();
        idle_inputs();
        for (int k = 1; k <= L2_BURST; k++) begin
            l2_dv = 1; l2_d = DW'(k);
            eval();
            check_val("t2_beat", ins_d, k);
            check_val("t2_dat_quiet", dat_dv, 0);
            adv();
        end
        eval();
        check_val("t2_fifo_empty", l2_dr, 0);
        adv();
        l2_dv = 0;

        // Both caches requesting continuously
        do_reset();
        glog.delete();
        ins_v = 1; ins_a = AW'(32'h100); dat_v = 1; dat_a = AW'(32'h200); l2_ar = 1;
        for (int i = 0; i < 4; i++) cycle();
`ifdef L2_ARB_FIXED_PRIO_EN
        exp_g = '{1, 1, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        check_val("t3_grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check_val("t3_grant_order", glog[i], exp_g[i]);
        drain();

        // Address stall with the other cache arriving meanwhile
        do_reset();
        glog.delete();
        ins_v = 1; ins_a = AW'(32'h100); l2_ar = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin dat_v = 1; dat_a = AW'(32'h200); end
            eval();
            check_val("t4_hold_addr", l2_a, 32'h100);
            check_val("t4_hold_src", l2_src, 0);
            check_val("t4_dat_blocked", dat_ar, 0);
            adv();
        end
        l2_ar = 1;
        eval();
        check_val("t4_ins_accept", ins_ar, 1);
        adv();
        ins_v = 0;
        eval();
        check_val("t4_dat_next", l2_a, 32'h200);
        check_val("t4_dat_accept", dat_ar, 1);
        adv();
        dat_v = 0;
        drain();

        // FIFO full: fifth request waits for the end of the first burst
        do_reset();
        ins_v = 1; l2_ar = 1;
        for (int i = 0; i < 4; i++) begin
            ins_a = AW'(32'h400 + i);
            cycle();
        end
        ins_a = AW'(32'h500);
        eval();
        check_val("t5_full_block", l2_av, 0);
        adv();
        for (int k = 0; k < L2_BURST; k++) begin
            l2_dv = 1; l2_d = DW'(k + 32);
            eval();
            check_val("t5_grant_on_pop", l2_av, k == L2_BURST - 1);
            adv();
        end
        ins_v = 0;
        drain();

        // D-cache stalls mid-burst
        do_reset();
        dat_v = 1; dat_a = AW'(32'h300); l2_ar = 1;
        cycle();
        idle_inputs();
        for (int k = 0; k < L2_BURST; k++) begin
            l2_dv = 1; l2_d = DW'(k + 10);
            if (k == 2) begin
                dat_take = 0;
                for (int s = 0; s < 2; s++) begin
                    eval();
                    check_val("t6_stall_ready", l2_dr, 0);
                    adv();
                end
                dat_take = 1;
            end
            eval();
            check_val("t6_beat", dat_d, k + 10);
            adv();
        end
        eval();
        check_val("t6_fifo_empty", l2_dr, 0);
        adv();

        // Reset during the second beat of a burst
        do_reset();
        ins_v = 1; ins_a = AW'(32'h600); l2_ar = 1;
        cycle();
        idle_inputs();
        l2_dv = 1; l2_d = DW'(1);
        cycle();
        rstn = 0; l2_d = DW'(2);
        cycle();
        rstn = 1;
        eval();
        check_val("t7_no_ack", l2_dr, 0);
        check_val("t7_no_fwd", ins_d, 0);
        adv();
        idle_inputs();
        ins_v = 1; ins_a = AW'(32'h700); l2_ar = 1;
        cycle();
        idle_inputs();
        drain();
        l2_dv = 1;
        eval();
        check_val("t7_count_restart", l2_dr, 0);
        adv();

        // Randomized traffic with protocol-compliant requesters
        idle_inputs();
        ip = 0; dp = 0;
        for (int c = 0; c < 800; c++) begin
            if (!ip && $urandom_range(0, 3) == 0) begin ip = 1; ins_a = AW'($urandom()); end
            if (!dp && $urandom_range(0, 3) == 0) begin dp = 1; dat_a = AW'($urandom()); end
            ins_v    = ip;
            dat_v    = dp;
            l2_ar    = ($urandom_range(0, 3) != 0);
            l2_dv    = ($urandom_range(0, 2) != 0);
            l2_d     = {$urandom(), $urandom(), $urandom(), $urandom()};
            ins_take = ($urandom_range(0, 4) != 0);
            dat_take = ($urandom_range(0, 4) != 0);
            rstn     = ($urandom_range(0, 199) != 0);
            eval();
            if (e_acc && e_gs == 0) ip = 0;
            if (e_acc && e_gs == 1) dp = 0;
            adv();
        end
        rstn = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
